// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- memory-mapped countdown timer behind the system bridge.
//
// The CPU sees three word registers selected by the bridge address bits [3:2]:
//   Addr 0  CTRL    bit0 Enable, bits[2:1] Mode (01 auto-reload, else one-shot),
//                   bit3 IM (1 = IRQ enabled); bits [31:4] read as 0
//   Addr 1  PRESET  32-bit reload value, read/write
//   Addr 2  COUNT   current count, read-only
//   Addr 3  reserved, reads 0, writes ignored
//
// A four-state FSM (IDLE -> LOAD -> CNT -> INT) loads PRESET into COUNT,
// counts down to zero and raises an internal irq_flag on expiry. IRQ is the
// flag gated by IM. In auto-reload mode the flag is a one-cycle pulse and the
// count restarts; in one-shot mode Enable is dropped and the flag is held
// until the CPU writes CTRL or PRESET.
//
// Ports
//   clk    in   1   system clock, all state changes on the rising edge
//   reset  in   1   synchronous active-high reset
//   Addr   in   2   word select
//   We     in   1   write strobe, already qualified by the bridge address hit
//   Din    in  32   write data
//   Dout   out 32   read data, combinational from Addr
//   IRQ    out  1   level interrupt request toward the CPU
// -----------------------------------------------------------------------------
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  // Architectural state
  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  // Next-state values produced by the combinational process
  state_t      state_nxt;
  logic [3:0]  ctrl_nxt;
  logic [31:0] preset_nxt;
  logic [31:0] count_nxt;
  logic        irq_flag_nxt;

  // Decoded control fields
  logic        enable;
  logic        auto_reload;
  logic        im;

  // Bus decode
  logic        wr_ctrl;
  logic        wr_preset;
  logic        raise_im;
  logic        fsm_set_irq;

  assign enable      = ctrl[0];
  assign auto_reload = (ctrl[2:1] == MODE_RELOAD);
  assign im          = ctrl[3];

  assign wr_ctrl   = We && (Addr == ADDR_CTRL);
  assign wr_preset = We && (Addr == ADDR_PRESET);

  // A CTRL write that turns IM on from off is unmasking a pending interrupt,
  // not acknowledging it, so it leaves irq_flag alone. Every other CTRL write
  // and every PRESET write acknowledges.
  assign raise_im = wr_ctrl && Din[3] && !ctrl[3];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM first, then CPU writes layered on top so the CPU
  // value wins wherever both touch the same register in one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt    = state;
    ctrl_nxt     = ctrl;
    preset_nxt   = preset;
    count_nxt    = count;
    irq_flag_nxt = irq_flag;
    fsm_set_irq  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end

      S_CNT: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (count <= 32'd1) begin
          // PRESET of 0 or 1 both expire here; COUNT never wraps below 0.
          count_nxt    = '0;
          irq_flag_nxt = 1'b1;
          fsm_set_irq  = 1'b1;
          state_nxt    = S_INT;
        end else begin
          count_nxt = count - 32'd1;
        end
      end

      S_INT: begin
        if (auto_reload) begin
          irq_flag_nxt = 1'b0;
          state_nxt    = S_LOAD;
        end else begin
          ctrl_nxt[0] = 1'b0;
          state_nxt   = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // CPU writes. A CTRL write overrides the one-shot Enable clear above.
    if (wr_ctrl) begin
      ctrl_nxt = Din[3:0];
    end
    if (wr_preset) begin
      preset_nxt = Din;
    end

    // Acknowledge, unless the FSM is setting the flag on this same edge.
    if (((wr_ctrl && !raise_im) || wr_preset) && !fsm_set_irq) begin
      irq_flag_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and interrupt output
  // ---------------------------------------------------------------------------
  always_comb begin
    Dout = '0;
    unique case (Addr)
      ADDR_CTRL:   Dout = {28'd0, ctrl};
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      default:     Dout = '0;
    endcase
  end

  assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer.sv
// -----------------------------------------------------------------------------
// tb_timer -- self-checking bench for the timer device.
// Clock edge numbering in comments follows the edge at which CTRL is written
// with Enable=1 as E0.
// -----------------------------------------------------------------------------
module tb_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .We    (We),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One clock edge; inputs change on the falling edge, write strobe dropped
  // shortly after the rising edge.
  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    We   = we;
    Addr = a;
    Din  = d;
    @(posedge clk);
    #1;
    We = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic check_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check_rd({tag, " ctrl"},   2'd0, 32'd0);
    check_rd({tag, " preset"}, 2'd1, 32'd0);
    check_rd({tag, " count"},  2'd2, 32'd0);
    check_rd({tag, " rsvd"},   2'd3, 32'd0);
    check_irq({tag, " irq"}, 1'b0);
  endtask

  // One-shot run with IM=1 for small presets: IRQ must appear after E3.
  task automatic run_boundary(input logic [31:0] p, input string tag);
    step(1'b1, 2'd1, p);
    step(1'b1, 2'd0, 32'h9);                        // E0
    idle(); check_irq({tag, " irq E1"}, 1'b0);
    idle(); check_irq({tag, " irq E2"}, 1'b0);
    idle(); check_irq({tag, " irq E3"}, 1'b1);
    check_rd({tag, " count E3"}, 2'd2, 32'd0);
    idle(); check_rd({tag, " ctrl E4"}, 2'd0, 32'h8);
  endtask

  initial begin
    logic [31:0] d;

    reset = 1'b1;
    We    = 1'b0;
    Addr  = 2'd0;
    Din   = '0;

    // Reset must win over a simultaneous write.
    step(1'b1, 2'd1, 32'hA5A5_A5A5);
    step(1'b1, 2'd0, 32'h0000_000F);
    reset = 1'b0;
    check_all_zero("reset");

    // ---- table: register access and one-shot countdown ----
    vecs[0]  = '{"wr preset 5",       1'b1, 2'd1, 32'h0000_0005, 2'd1, 32'h5, 1'b0};
    vecs[1]  = '{"ctrl upper bits",   1'b1, 2'd0, 32'hFFFF_FFF0, 2'd0, 32'h0, 1'b0};
    vecs[2]  = '{"count after reset", 1'b0, 2'd0, 32'h0,         2'd2, 32'h0, 1'b0};
    vecs[3]  = '{"rsvd read",         1'b0, 2'd0, 32'h0,         2'd3, 32'h0, 1'b0};
    vecs[4]  = '{"count write ign",   1'b1, 2'd2, 32'h0000_1234, 2'd2, 32'h0, 1'b0};
    vecs[5]  = '{"rsvd write ign",    1'b1, 2'd3, 32'hDEAD_BEEF, 2'd3, 32'h0, 1'b0};
    vecs[6]  = '{"wr preset 3",       1'b1, 2'd1, 32'h0000_0003, 2'd1, 32'h3, 1'b0};
    vecs[7]  = '{"os ctrl E0",        1'b1, 2'd0, 32'h0000_0009, 2'd0, 32'h9, 1'b0};
    vecs[8]  = '{"os count E1",       1'b0, 2'd0, 32'h0,         2'd2, 32'h0, 1'b0};
    vecs[9]  = '{"os count E2",       1'b0, 2'd0, 32'h0,         2'd2, 32'h3, 1'b0};
    vecs[10] = '{"os count E3",       1'b0, 2'd0, 32'h0,         2'd2, 32'h2, 1'b0};
    vecs[11] = '{"os count E4",       1'b0, 2'd0, 32'h0,         2'd2, 32'h1, 1'b0};
    vecs[12] = '{"os count E5",       1'b0, 2'd0, 32'h0,         2'd2, 32'h0, 1'b1};
    vecs[13] = '{"os ctrl E6",        1'b0, 2'd0, 32'h0,         2'd0, 32'h8, 1'b1};
    vecs[14] = '{"os irq held",       1'b0, 2'd0, 32'h0,         2'd0, 32'h8, 1'b1};
    vecs[15] = '{"os preset ack",     1'b1, 2'd1, 32'h0000_0007, 2'd1, 32'h7, 1'b0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].we, vecs[i].waddr, vecs[i].din);
      check_rd({vecs[i].name, " dout"}, vecs[i].raddr, vecs[i].exp_dout);
      check_irq({vecs[i].name, " irq"}, vecs[i].exp_irq);
    end

    // ---- auto-reload: PRESET=2, period 4, one-cycle pulse ----
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'hB);                        // E0
    for (int k = 1; k <= 21; k++) begin
      idle();
      check_irq($sformatf("ar irq E%0d", k), (k >= 4) && ((k - 4) % 4 == 0));
    end
    check_rd("ar enable kept", 2'd0, 32'hB);
    step(1'b1, 2'd0, 32'h0);                        // E22, state LOAD -> CNT
    idle(); idle(); idle();

    // ---- boundary presets 0 and 1 ----
    run_boundary(32'd0, "p0");
    run_boundary(32'd1, "p1");

    // ---- all-ones preset, IM=0: plain decrement, no wrap ----
    step(1'b1, 2'd1, 32'hFFFF_FFFF);
    step(1'b1, 2'd0, 32'h1);                        // E0
    idle(); idle();
    check_rd("max count E2", 2'd2, 32'hFFFF_FFFF);
    for (int k = 0; k < 10; k++) idle();
    check_rd("max count E12", 2'd2, 32'hFFFF_FFF5);
    step(1'b1, 2'd0, 32'h0);
    idle(); idle();

    // ---- mid-count disable and re-enable ----
    step(1'b1, 2'd1, 32'd10);
    step(1'b1, 2'd0, 32'h9);                        // E0
    for (int k = 0; k < 6; k++) idle();
    check_rd("dis count E6", 2'd2, 32'd6);
    step(1'b1, 2'd0, 32'h8);                        // E7: still counting
    check_rd("dis count E7", 2'd2, 32'd5);
    idle();
    check_rd("dis count E8", 2'd2, 32'd5);
    idle();
    check_rd("dis count E9", 2'd2, 32'd5);
    check_irq("dis irq", 1'b0);
    step(1'b1, 2'd1, 32'd4);
    step(1'b1, 2'd0, 32'h9);                        // E0
    idle();
    check_rd("reen count E1", 2'd2, 32'd5);
    idle();
    check_rd("reen count E2", 2'd2, 32'd4);
    step(1'b1, 2'd0, 32'h0);
    idle(); idle();

    // ---- masked expiry, then unmask ----
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h1);                        // E0
    idle(); idle(); idle();                         // E3 expiry
    check_rd("mask count E3", 2'd2, 32'd0);
    check_irq("mask irq E3", 1'b0);
    idle();
    check_rd("mask ctrl E4", 2'd0, 32'h0);
    check_irq("mask irq E4", 1'b0);
    step(1'b1, 2'd0, 32'h8);
    check_irq("unmask irq", 1'b1);
    step(1'b1, 2'd1, 32'd0);
    check_irq("unmask ack", 1'b0);

    // ---- reset mid-count ----
    step(1'b1, 2'd1, 32'd20);
    step(1'b1, 2'd0, 32'h9);                        // E0
    for (int k = 0; k < 15; k++) idle();
    check_rd("rst count E15", 2'd2, 32'd7);
    reset = 1'b1;
    step(1'b1, 2'd0, 32'hF);
    reset = 1'b0;
    check_all_zero("midrst");
    idle();
    check_rd("midrst idle count", 2'd2, 32'd0);

    // ---- CTRL write landing on the one-shot INT cycle ----
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'h9);                        // E0
    idle(); idle(); idle(); idle();                 // E4 expiry
    check_irq("sim irq E4", 1'b1);
    step(1'b1, 2'd0, 32'h9);                        // E5, INT cycle
    check_rd("sim ctrl E5", 2'd0, 32'h9);
    check_irq("sim irq E5", 1'b0);
    idle(); idle();                                 // E7: restarted count
    check_rd("sim count E7", 2'd2, 32'd2);

    rd(2'd0, d);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
